// File: rtl/jk_seq_pkg.sv
// Shared encodings, FSM states and the per-bit J/K decode used by the
// JK sequencer and its shadow bank.
package jk_seq_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Returns {j,k} for one flip-flop; unmasked bits and HOLD leave the bit alone.
    function automatic logic [1:0] jk_decode(input logic [1:0] op, input logic mask_bit);
        logic [1:0] jk;
        jk = 2'b00;
        if (mask_bit) begin
            case (op)
                OP_CLEAR:  jk = 2'b01;
                OP_SET:    jk = 2'b10;
                OP_TOGGLE: jk = 2'b11;
                default:   jk = 2'b00;
            endcase
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_shadow_bank.sv
// Rising-edge twin of the downstream JK flip-flop bank: applies {j,k} to
// every bit whenever the update strobe is high.
module jk_shadow_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             upd_i,
    input  logic [WIDTH-1:0] j_i,
    input  logic [WIDTH-1:0] k_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (upd_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j_i[i], k_i[i]})
                    2'b01:   q_d[i] = 1'b0;
                    2'b10:   q_d[i] = 1'b1;
                    2'b11:   q_d[i] = ~q_q[i];
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer driving J/K/enable of a falling-edge JK flip-flop bank
// with timed enable bursts, plus a shadow copy of the bank state.
//
// state    | meaning
// ST_IDLE  | ready for a command
// ST_SETUP | j/k driven, enable low, one cycle of setup before first pulse
// ST_PULSE | enable high, one pulse per cycle until the counter reaches 0
// ST_DONE  | done pulse, aborted qualifies it
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_repeat,
    input  logic             abort,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] shadow_q
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aborted_q, aborted_d;
    logic             drive;
    logic [WIDTH-1:0] j_drv, k_drv;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d   = ST_SETUP;
                    op_d      = cmd_op;
                    mask_d    = cmd_mask;
                    // Counter holds pulses-remaining minus 1, so all-ones repeat never wraps.
                    cnt_d     = cmd_repeat;
                    aborted_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (op_q == OP_HOLD) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_HOLD;
            mask_q    <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    // Outputs decode registered state only, so they move on rising edges alone.
    assign drive = (state_q == ST_SETUP) || (state_q == ST_PULSE);

    always_comb begin
        j_drv = '0;
        k_drv = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_drv[i], k_drv[i]} = drive ? jk_decode(op_q, mask_q[i]) : 2'b00;
        end
    end

    assign j         = j_drv;
    assign k         = k_drv;
    assign enable    = (state_q == ST_PULSE);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign aborted   = (state_q == ST_DONE) && aborted_q;

    jk_shadow_bank #(.WIDTH(WIDTH)) u_shadow (
        .clk   (clk),
        .reset (reset),
        .upd_i (state_q == ST_PULSE),
        .j_i   (j_drv),
        .k_i   (k_drv),
        .q_o   (shadow_q)
    );

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed, table-driven bench for jk_seq_ctrl with hand-computed expectations.
module tb_jk_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_mask;
    logic [3:0] cmd_repeat;
    logic       abort;
    logic [3:0] j, k;
    logic       enable, busy, done, aborted;
    logic [3:0] shadow_q;

    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] sh_hist [0:31];

    typedef struct {
        logic [1:0] op;
        logic [3:0] mask;
        logic [3:0] rep;
        int         abort_at;   // 0 none, -1 in SETUP, n>0 during n-th pulse
        logic [3:0] ej;
        logic [3:0] ek;
        int         epulses;
        int         elat;
        logic       eab;
        logic [3:0] esh;
    } vec_t;

    vec_t vecs [10];

    jk_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mask   (cmd_mask),
        .cmd_repeat (cmd_repeat),
        .abort      (abort),
        .j          (j),
        .k          (k),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .shadow_q   (shadow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int   c;
        int   pulses;
        logic [3:0] js, ks;
        logic prev_en, hold_ok, setup_en;
        cmd_op     = v.op;
        cmd_mask   = v.mask;
        cmd_repeat = v.rep;
        cmd_valid  = 1'b1;
        chk("ready_before", {31'd0, cmd_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        // While busy, a different command stays offered; it must be ignored.
        if (v.abort_at > 0) begin
            cmd_op   = 2'b10;
            cmd_mask = 4'hF;
        end else begin
            cmd_valid = 1'b0;
        end
        c = 1; js = j; ks = k; setup_en = enable;
        chk("setup_busy", {31'd0, busy}, 1);
        pulses = 0; prev_en = 1'b0; hold_ok = 1'b1;
        while (!done && c < 40) begin
            if (prev_en && pulses > 0) sh_hist[pulses-1] = shadow_q;
            if (enable) begin
                pulses++;
                if (j !== js || k !== ks) hold_ok = 1'b0;
            end
            abort = (v.abort_at < 0 && c == 1) || (enable && pulses == v.abort_at);
            prev_en = enable;
            @(negedge clk);
            c++;
        end
        abort = 1'b0;
        cmd_valid = 1'b0;
        if (prev_en && pulses > 0) sh_hist[pulses-1] = shadow_q;
        chk("done_seen", {31'd0, done}, 1);
        chk("setup_j", {28'd0, js}, {28'd0, v.ej});
        chk("setup_k", {28'd0, ks}, {28'd0, v.ek});
        chk("setup_enable", {31'd0, setup_en}, 0);
        chk("pulse_count", pulses, v.epulses);
        chk("latency", c, v.elat);
        chk("aborted", {31'd0, aborted}, {31'd0, v.eab});
        chk("shadow", {28'd0, shadow_q}, {28'd0, v.esh});
        chk("jk_held", {31'd0, hold_ok}, 1);
        chk("done_jk_en", {23'd0, j, k, enable}, 0);
        @(negedge clk);
        chk("idle_after", {29'd0, cmd_ready, busy, done}, 3'b100);
        @(negedge clk);
        chk("stay_idle", {27'd0, busy, shadow_q}, {27'd0, 1'b0, v.esh});
    endtask

    initial begin
        vecs[0] = '{2'b10, 4'b0101, 4'd0,  0, 4'b0101, 4'b0000, 1,  3,  1'b0, 4'b0101};
        vecs[1] = '{2'b11, 4'b1111, 4'd2,  0, 4'b1111, 4'b1111, 3,  5,  1'b0, 4'b1010};
        vecs[2] = '{2'b01, 4'b0010, 4'd0,  0, 4'b0000, 4'b0010, 1,  3,  1'b0, 4'b1000};
        vecs[3] = '{2'b00, 4'b1111, 4'd3,  0, 4'b0000, 4'b0000, 0,  2,  1'b0, 4'b1000};
        vecs[4] = '{2'b11, 4'b0001, 4'd15, 0, 4'b0001, 4'b0001, 16, 18, 1'b0, 4'b1000};
        vecs[5] = '{2'b11, 4'b0001, 4'd7,  3, 4'b0001, 4'b0001, 3,  5,  1'b1, 4'b1001};
        vecs[6] = '{2'b10, 4'b0000, 4'd1,  0, 4'b0000, 4'b0000, 2,  4,  1'b0, 4'b1001};
        vecs[7] = '{2'b10, 4'b1111, 4'd2,  3, 4'b1111, 4'b0000, 3,  5,  1'b1, 4'b1111};
        vecs[8] = '{2'b01, 4'b0110, 4'd1,  0, 4'b0000, 4'b0110, 2,  4,  1'b0, 4'b1001};
        vecs[9] = '{2'b11, 4'b1111, 4'd3, -1, 4'b1111, 4'b1111, 0,  2,  1'b1, 4'b1001};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mask = 4'h0;
        cmd_repeat = 4'h0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {18'd0, j, k, enable, busy, done, aborted, shadow_q}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, cmd_ready}, 1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i]);
            if (i == 1) begin
                chk("toggle_hist0", {28'd0, sh_hist[0]}, 32'b1010);
                chk("toggle_hist1", {28'd0, sh_hist[1]}, 32'b0101);
                chk("toggle_hist2", {28'd0, sh_hist[2]}, 32'b1010);
            end
        end

        // Reset in the middle of a SET burst
        cmd_op = 2'b10; cmd_mask = 4'hF; cmd_repeat = 4'd7; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_pulse_enable", {31'd0, enable}, 1);
        chk("mid_pulse_shadow", {28'd0, shadow_q}, 32'hF);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", {19'd0, j, k, enable, busy, done, shadow_q}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_ready", {30'd0, cmd_ready, busy}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
